fetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the next-generation core. Replaces the bare PC

---
 rtl/cpu_pkg.sv | 13 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared defaults for the core front end: PC and instruction widths, prefetch
// queue depth, reset fetch address and the NOP encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;
    localparam int PC_W_DEF     = 8;
    localparam int INSTR_W_DEF  = 32;
    localparam int DEPTH_DEF    = 4;
    localparam int RESET_PC_DEF = 0;
    localparam logic [INSTR_W_DEF-1:0] NOP = 32'h0;
endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with wrap-around read/write pointers carrying one extra
// bit to tell full from empty. flush has priority over push and pop.
// Ports:
//   clk, rst        clock, async active-high reset (pointers only)
//   flush           empty the FIFO at the next edge
//   push, din       write din at the tail
//   pop, dout       remove the head; dout shows the head combinationally
//   empty, full     status flags
//   count           number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module sync_fifo
    import cpu_pkg::*;
#(
    parameter int WIDTH = PC_W_DEF + INSTR_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch front end: owns the fetch PC, issues reads to a
// synchronous instruction memory and streams {pc, pc+1, instruction} to decode
// through a prefetch queue. A redirect from execute flushes all wrong-path work
// and restarts fetch at the target in the same cycle.
// Ports:
//   clk, rst                    clock, async active-high reset
//   imem_addr, imem_rd_en       read request to instruction memory
//   imem_data                   instruction for last cycle's request
//   redirect_valid, redirect_pc control transfer resolved by execute
//   out_valid, out_ready        valid/ready handshake to decode
//   out_instr, out_pc           head instruction and its address
//   out_pc_plus1                out_pc + 1 (modulo 2**PC_W)
// -----------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int          PC_W     = PC_W_DEF,
    parameter int          INSTR_W  = INSTR_W_DEF,
    parameter int          DEPTH    = DEPTH_DEF,
    parameter int unsigned RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_rd_en,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_pc_plus1
);
    localparam int AW = $clog2(DEPTH);
    localparam int QW = PC_W + INSTR_W;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

    logic [PC_W-1:0] fetch_pc;
    logic            vld_p1;
    logic [PC_W-1:0] pc_p1;
    logic [AW:0]     q_count;
    logic            q_empty;
    logic            q_full;
    logic [QW-1:0]   q_dout;
    logic            redirect;
    logic            credit;
    logic            issue;
    logic            push;
    logic            pop;
    logic [AW+1:0]   occupancy;

    // ---- stage p0: issue to instruction memory ----
    // Credit counts the queue plus the request still in flight, using occupancy
    // at the start of the cycle so a same-cycle pop never over-commits a slot.
    assign redirect   = redirect_valid && !rst;
    assign occupancy  = {1'b0, q_count} + (AW+2)'(vld_p1);
    assign credit     = !q_full && (occupancy < (AW+2)'(DEPTH));
    assign issue      = !rst && (redirect_valid || credit);
    assign imem_rd_en = issue;
    assign imem_addr  = redirect ? redirect_pc : fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= PC_W'(RESET_PC);
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= issue;
            if (redirect)   fetch_pc <= pc_inc(redirect_pc);
            else if (issue) fetch_pc <= pc_inc(fetch_pc);
        end
    end

    always_ff @(posedge clk) begin
        pc_p1 <= imem_addr;
    end

    // ---- stage p1: memory response into the prefetch queue ----
    // A redirect discards the response arriving now and any pop asked for now.
    assign push = vld_p1 && !redirect;
    assign pop  = !q_empty && out_ready && !redirect;

    sync_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .din   ({pc_p1, imem_data}),
        .dout  (q_dout),
        .empty (q_empty),
        .full  (q_full),
        .count (q_count)
    );

    // ---- stage p2: queue head to decode ----
    assign out_valid    = !q_empty;
    assign out_pc       = q_dout[QW-1:INSTR_W];
    assign out_instr    = q_dout[INSTR_W-1:0];
    assign out_pc_plus1 = pc_inc(out_pc);
endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;

    logic               clk;
    logic               rst;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_rd_en;
    logic [INSTR_W-1:0] imem_data;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [PC_W-1:0]    out_pc_plus1;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rd_en     (imem_rd_en),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus1   (out_pc_plus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: low byte equals the address.
    function automatic logic [31:0] im_word(input logic [7:0] a);
        return {8'hA5, a ^ 8'h3C, 8'h00, a};
    endfunction

    initial imem_data = NOP;
    always @(posedge clk) if (imem_rd_en) imem_data <= im_word(imem_addr);

    // Leaves the bench at the falling edge that opens cycle 0 after reset.
    task automatic apply_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", imem_rd_en); end
        checks++;
        if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", imem_addr); end
    endtask

    task automatic test_stream();
        apply_reset();
        out_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            if (t != 0) @(negedge clk);
            #1;
            checks++;
            if (imem_rd_en !== 1'b1 || imem_addr !== 8'(t)) begin
                errors++;
                $display("FAIL stream_issue t=%0d got en=%b addr=%h want en=1 addr=%h", t, imem_rd_en, imem_addr, 8'(t));
            end
            checks++;
            if (out_valid !== (t >= 2)) begin
                errors++;
                $display("FAIL stream_valid t=%0d got %b want %b", t, out_valid, (t >= 2));
            end
            if (t >= 2) begin
                checks++;
                if (out_pc !== 8'(t-2) || out_instr !== im_word(8'(t-2)) || out_pc_plus1 !== 8'(t-1)) begin
                    errors++;
                    $display("FAIL stream_head t=%0d got pc=%h instr=%h p1=%h want pc=%h instr=%h p1=%h",
                             t, out_pc, out_instr, out_pc_plus1, 8'(t-2), im_word(8'(t-2)), 8'(t-1));
                end
            end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        for (int t = 0; t < 18; t++) begin
            if (t != 0) @(negedge clk);
            out_ready = (t >= 10);
            #1;
            checks++;
            if (imem_rd_en !== ((t < 4) || (t >= 11))) begin
                errors++;
                $display("FAIL stall_rd_en t=%0d got %b want %b", t, imem_rd_en, ((t < 4) || (t >= 11)));
            end
            if (t < 4 || t >= 11) begin
                checks++;
                if (imem_addr !== ((t < 4) ? 8'(t) : 8'(t-7))) begin
                    errors++;
                    $display("FAIL stall_addr t=%0d got %h want %h", t, imem_addr, ((t < 4) ? 8'(t) : 8'(t-7)));
                end
            end
            if (t >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== ((t < 10) ? 8'h00 : 8'(t-10))) begin
                    errors++;
                    $display("FAIL stall_head t=%0d got v=%b pc=%h want v=1 pc=%h", t, out_valid, out_pc,
                             ((t < 10) ? 8'h00 : 8'(t-10)));
                end
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_redirect();
        apply_reset();
        for (int t = 0; t < 10; t++) begin
            if (t != 0) @(negedge clk);
            redirect_valid = (t == 4);
            redirect_pc = (t == 4) ? 8'h40 : 8'h00;
            out_ready = (t >= 4);
            #1;
            if (t == 4) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 8'h00) begin
                    errors++; $display("FAIL redir_pre_head got v=%b pc=%h want v=1 pc=00", out_valid, out_pc);
                end
                checks++;
                if (imem_rd_en !== 1'b1 || imem_addr !== 8'h40) begin
                    errors++; $display("FAIL redir_issue got en=%b addr=%h want en=1 addr=40", imem_rd_en, imem_addr);
                end
            end
            if (t == 5) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got v=%b want 0", out_valid); end
                checks++;
                if (imem_rd_en !== 1'b1 || imem_addr !== 8'h41) begin
                    errors++; $display("FAIL redir_next_issue got en=%b addr=%h want en=1 addr=41", imem_rd_en, imem_addr);
                end
            end
            if (t >= 6) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 8'(8'h40 + t - 6) || out_pc_plus1 !== 8'(8'h41 + t - 6)
                    || out_instr !== im_word(8'(8'h40 + t - 6))) begin
                    errors++;
                    $display("FAIL redir_target t=%0d got v=%b pc=%h p1=%h want v=1 pc=%h p1=%h",
                             t, out_valid, out_pc, out_pc_plus1, 8'(8'h40 + t - 6), 8'(8'h41 + t - 6));
                end
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc;
        apply_reset();
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            if (t != 0) @(negedge clk);
            redirect_valid = (t == 0);
            redirect_pc = 8'hFE;
            #1;
            if (t <= 2) begin
                exp_pc = 8'hFE + 8'(t);
                checks++;
                if (imem_rd_en !== 1'b1 || imem_addr !== exp_pc) begin
                    errors++; $display("FAIL wrap_issue t=%0d got addr=%h want %h", t, imem_addr, exp_pc);
                end
            end
            if (t >= 2) begin
                exp_pc = 8'hFE + 8'(t - 2);
                checks++;
                if (out_valid !== 1'b1 || out_pc !== exp_pc || out_pc_plus1 !== exp_pc + 8'd1) begin
                    errors++;
                    $display("FAIL wrap_head t=%0d got v=%b pc=%h p1=%h want v=1 pc=%h p1=%h",
                             t, out_valid, out_pc, out_pc_plus1, exp_pc, exp_pc + 8'd1);
                end
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        out_ready = 1'b1;
        for (int t = 0; t < 11; t++) begin
            if (t != 0) @(negedge clk);
            redirect_valid = (t == 5) || (t == 6);
            redirect_pc = (t == 5) ? 8'h10 : 8'h20;
            #1;
            if (t == 6) begin
                checks++;
                if (imem_rd_en !== 1'b1 || imem_addr !== 8'h20) begin
                    errors++; $display("FAIL b2b_issue got en=%b addr=%h want en=1 addr=20", imem_rd_en, imem_addr);
                end
            end
            if (t == 6 || t == 7) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL b2b_flushed t=%0d got v=%b pc=%h want v=0", t, out_valid, out_pc);
                end
            end
            if (t >= 8) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 8'(8'h20 + t - 8)) begin
                    errors++;
                    $display("FAIL b2b_target t=%0d got v=%b pc=%h want v=1 pc=%h", t, out_valid, out_pc, 8'(8'h20 + t - 8));
                end
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int t = 0; t < 7; t++) begin
            if (t != 0) @(negedge clk);
            #1;
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_full got v=%b want 1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_rd_en !== 1'b0) begin
            errors++; $display("FAIL areset_immediate got v=%b en=%b want v=0 en=0", out_valid, imem_rd_en);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            if (t != 0) @(negedge clk);
            #1;
            if (t == 0) begin
                checks++;
                if (imem_rd_en !== 1'b1 || imem_addr !== 8'h00) begin
                    errors++; $display("FAIL areset_restart got en=%b addr=%h want en=1 addr=00", imem_rd_en, imem_addr);
                end
            end
            checks++;
            if (out_valid !== (t >= 2) || (t >= 2 && out_pc !== 8'(t-2))) begin
                errors++;
                $display("FAIL areset_head t=%0d got v=%b pc=%h want v=%b pc=%h", t, out_valid, out_pc, (t >= 2), 8'(t-2));
            end
        end
    endtask

    // Reference: every issued fetch since the last flush is owed to decode in
    // order, becomes visible two cycles after issue, and the number owed caps
    // new issues at DEPTH.
    task automatic test_random();
        logic [7:0] mq[$];
        int         mt[$];
        logic [7:0] m_fetch;
        logic       exp_v;
        logic       exp_en;
        logic [7:0] exp_addr;
        apply_reset();
        m_fetch = 8'h00;
        for (int t = 0; t < 600; t++) begin
            if (t != 0) @(negedge clk);
            out_ready = ($urandom_range(0, 99) < 70);
            redirect_valid = ($urandom_range(0, 99) < 6);
            redirect_pc = 8'($urandom);
            #1;
            exp_v = 1'b0;
            if (mq.size() > 0) exp_v = (mt[0] + 2 <= t);
            if (redirect_valid) begin
                exp_en = 1'b1;
                exp_addr = redirect_pc;
            end else begin
                exp_en = (mq.size() < DEPTH);
                exp_addr = m_fetch;
            end
            checks++;
            if (out_valid !== exp_v) begin
                errors++; $display("FAIL rand_valid t=%0d got %b want %b", t, out_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (out_pc !== mq[0] || out_instr !== im_word(mq[0]) || out_pc_plus1 !== mq[0] + 8'd1) begin
                    errors++;
                    $display("FAIL rand_head t=%0d got pc=%h instr=%h p1=%h want pc=%h", t, out_pc, out_instr, out_pc_plus1, mq[0]);
                end
            end
            checks++;
            if (imem_rd_en !== exp_en || imem_addr !== exp_addr) begin
                errors++;
                $display("FAIL rand_issue t=%0d got en=%b addr=%h want en=%b addr=%h", t, imem_rd_en, imem_addr, exp_en, exp_addr);
            end
            if (redirect_valid) begin
                mq.delete();
                mt.delete();
                mq.push_back(redirect_pc);
                mt.push_back(t);
                m_fetch = redirect_pc + 8'd1;
            end else begin
                if (exp_v && out_ready) begin
                    void'(mq.pop_front());
                    void'(mt.pop_front());
                end
                if (exp_en) begin
                    mq.push_back(m_fetch);
                    mt.push_back(t);
                    m_fetch = m_fetch + 8'd1;
                end
            end
        end
        redirect_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
